// File: rtl/monkey_motion_ctrl.sv
// -----------------------------------------------------------------------------
// monkey_motion_ctrl
//
// Life-cycle sequencer for the player monkey. Sits between the keyboard
// decoder and the move/collision block. It gates the raw key levels into
// movement commands according to the monkey's state (idle, ground, air, climb,
// hit, respawn, game over). It also issues a one-clock respawn reset to the
// move block and tracks lives, the fall-time limit and post-respawn
// invulnerability. Frame-paced transitions advance only on startOfFrame.
// Hits, game start and reset act on any clock.
//
// Ports
//   clk, resetN          system clock, asynchronous active-low reset
//   startOfFrame         one-clock pulse per video frame
//   gameStart            one-clock start / restart request
//   left/right/up/downPressed  raw key levels
//   onLedge, onRope      footing information from the collision block
//   objectHit            contact with an enemy or hazard
//   left/right/up/downCmd      registered, gated movement commands
//   moveResetN           active-low one-clock reset to the move block (respawn)
//   motionState          0 IDLE,1 GROUND,2 AIR,3 CLIMB,4 HIT,5 RESPAWN,6 GAMEOVER
//   livesLeft            remaining lives
//   invincible           high while the invulnerability counter is nonzero
//   gameOver             high in GAMEOVER
// -----------------------------------------------------------------------------
module monkey_motion_ctrl #(
  parameter int unsigned INIT_LIVES      = 3,
  parameter int unsigned INVULN_FRAMES   = 60,
  parameter int unsigned HIT_FRAMES      = 45,
  parameter int unsigned MAX_FALL_FRAMES = 40
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       gameStart,
  input  logic       leftPressed,
  input  logic       rightPressed,
  input  logic       upPressed,
  input  logic       downPressed,
  input  logic       onLedge,
  input  logic       onRope,
  input  logic       objectHit,
  output logic       leftCmd,
  output logic       rightCmd,
  output logic       upCmd,
  output logic       downCmd,
  output logic       moveResetN,
  output logic [2:0] motionState,
  output logic [1:0] livesLeft,
  output logic       invincible,
  output logic       gameOver
);

  localparam int unsigned INV_W  = $clog2(INVULN_FRAMES + 1);
  localparam int unsigned HIT_W  = $clog2(HIT_FRAMES + 1);
  localparam int unsigned FALL_W = $clog2(MAX_FALL_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GROUND   = 3'd1,
    AIR      = 3'd2,
    CLIMB    = 3'd3,
    HIT      = 3'd4,
    RESPAWN  = 3'd5,
    GAMEOVER = 3'd6
  } motionStateT;

  motionStateT       state, nextState;
  logic [INV_W-1:0]  invCnt, invCntNext;
  logic [HIT_W-1:0]  hitCnt, hitCntNext;
  logic [FALL_W-1:0] fallCnt, fallCntNext;
  logic [1:0]        livesNext;
  logic              upSeen, upSeenNext;
  logic              jumpActive, jumpNext;
  logic              hitNow;
  logic              leftNext, rightNext, upNext, downNext;

  assign motionState = state;

  // A hit counts only while the monkey is in play and not protected.
  assign hitNow = objectHit && !invincible &&
                  ((state == GROUND) || (state == AIR) || (state == CLIMB));

  // Jump one-shot: a fresh rising level of upPressed at a frame boundary, while
  // standing, opens a one-frame window; the next frame boundary closes it.
  // upSeen remembers the level sampled at the previous frame boundary so a
  // held key cannot re-trigger.
  assign jumpNext   = startOfFrame ? ((state == GROUND) && upPressed && !upSeen)
                                   : jumpActive;
  assign upSeenNext = startOfFrame ? upPressed : upSeen;

  // Invulnerability is (re)loaded in the respawn clock and otherwise drains one
  // per frame in every state.
  always_comb begin
    invCntNext = invCnt;
    if (state == RESPAWN) begin
      invCntNext = INV_W'(INVULN_FRAMES);
    end else if (startOfFrame && (invCnt != '0)) begin
      invCntNext = invCnt - 1'b1;
    end
  end

  // Next-state logic. A hit pre-empts every frame-paced transition, so the
  // fall and hit counters hold whenever hitNow is set.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    nextState   = state;
    hitCntNext  = hitCnt;
    fallCntNext = fallCnt;
    livesNext   = livesLeft;

    if (hitNow) begin
      nextState  = HIT;
      hitCntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (gameStart) nextState = RESPAWN;
        end

        RESPAWN: nextState = GROUND;

        GROUND: begin
          if (startOfFrame) begin
            if (onRope && (upPressed || downPressed)) begin
              nextState = CLIMB;
            end else if (!onLedge && !onRope) begin
              nextState   = AIR;
              fallCntNext = '0;
            end
          end
        end

        AIR: begin
          if (startOfFrame) begin
            if (onRope) begin
              nextState = CLIMB;
            end else if (onLedge) begin
              nextState = GROUND;
            end else begin
              fallCntNext = fallCnt + 1'b1;
              if (fallCntNext == FALL_W'(MAX_FALL_FRAMES)) begin
                nextState  = HIT;
                hitCntNext = '0;
              end
            end
          end
        end

        CLIMB: begin
          if (startOfFrame && !onRope) begin
            if (onLedge) begin
              nextState = GROUND;
            end else begin
              nextState   = AIR;
              fallCntNext = '0;
            end
          end
        end

        HIT: begin
          if (startOfFrame) begin
            if ((hitCnt + 1'b1) == HIT_W'(HIT_FRAMES)) begin
              hitCntNext = '0;
              if (livesLeft <= 2'd1) begin
                livesNext = 2'd0;
                nextState = GAMEOVER;
              end else begin
                livesNext = livesLeft - 2'd1;
                nextState = RESPAWN;
              end
            end else begin
              hitCntNext = hitCnt + 1'b1;
            end
          end
        end

        GAMEOVER: begin
          if (gameStart) begin
            livesNext = 2'(INIT_LIVES);
            nextState = RESPAWN;
          end
        end

        default: nextState = IDLE;  // unused code 7 recovers to IDLE
      endcase
    end
  end

  // Command gating keyed on the state being entered, so the registered
  // commands always agree with the registered motionState.
  always_comb begin
    leftNext  = 1'b0;
    rightNext = 1'b0;
    upNext    = 1'b0;
    downNext  = 1'b0;
    case (nextState)
      GROUND: begin
        leftNext  = leftPressed;
        rightNext = rightPressed;
        upNext    = jumpNext;
      end
      AIR: begin
        leftNext  = leftPressed;
        rightNext = rightPressed;
      end
      CLIMB: begin
        leftNext  = leftPressed;
        rightNext = rightPressed;
        upNext    = upPressed;
        downNext  = downPressed;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      livesLeft  <= 2'(INIT_LIVES);
      invCnt     <= '0;
      hitCnt     <= '0;
      fallCnt    <= '0;
      upSeen     <= 1'b0;
      jumpActive <= 1'b0;
      leftCmd    <= 1'b0;
      rightCmd   <= 1'b0;
      upCmd      <= 1'b0;
      downCmd    <= 1'b0;
      moveResetN <= 1'b1;
      invincible <= 1'b0;
      gameOver   <= 1'b0;
    end else begin
      state      <= nextState;
      livesLeft  <= livesNext;
      invCnt     <= invCntNext;
      hitCnt     <= hitCntNext;
      fallCnt    <= fallCntNext;
      upSeen     <= upSeenNext;
      jumpActive <= jumpNext;
      leftCmd    <= leftNext;
      rightCmd   <= rightNext;
      upCmd      <= upNext;
      downCmd    <= downNext;
      moveResetN <= (nextState != RESPAWN);
      invincible <= (invCntNext != '0);
      gameOver   <= (nextState == GAMEOVER);
    end
  end

endmodule

// File: doc/monkey_motion_ctrl.md
Name: monkey_motion_ctrl

Overview:
- Sequencer for the player-monkey movement datapath. It sits between the keyboard decoder and the monkey move/collision block.
- It owns the monkey's life-cycle state (idle, ground, air, climb, hit, respawn, game over) and produces gated movement commands and a respawn reset pulse for the move block.
- It tracks lives, the fall-time limit and post-respawn invulnerability.
- All state transitions except hit, start and reset are frame-paced by startOfFrame.

Parameters:
- INIT_LIVES, 3, lives loaded at game start; range 1..3.
- INVULN_FRAMES, 60, frames after respawn during which objectHit is ignored.
- HIT_FRAMES, 45, frames spent in HIT before the life is decremented.
- MAX_FALL_FRAMES, 40, consecutive AIR frames that count as a fatal fall.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clock pulse per frame (30 Hz)
- gameStart  in  1  one-clock start/restart request
- leftPressed  in  1  raw key level
- rightPressed  in  1  raw key level
- upPressed  in  1  raw key level
- downPressed  in  1  raw key level
- onLedge  in  1  monkey standing on a ledge (collision with floor edge, not an object)
- onRope  in  1  monkey overlapping a rope
- objectHit  in  1  monkey touched an enemy or hazard
- leftCmd  out  1  gated left command to move block
- rightCmd  out  1  gated right command to move block
- upCmd  out  1  gated up command to move block
- downCmd  out  1  gated down command to move block
- moveResetN  out  1  active-low, one-clock respawn reset to move block
- motionState  out  3  0 IDLE, 1 GROUND, 2 AIR, 3 CLIMB, 4 HIT, 5 RESPAWN, 6 GAMEOVER
- livesLeft  out  2  remaining lives
- invincible  out  1  high while the invulnerability counter is nonzero
- gameOver  out  1  high in GAMEOVER

Behaviour:
- Reset values:
  - state IDLE; livesLeft = INIT_LIVES; all Cmd outputs 0.
  - moveResetN = 1; invincible = 0; gameOver = 0; all counters 0.
- Outputs are registered; each Cmd reflects its inputs with 1 clk latency.
- IDLE: all Cmd outputs 0. gameStart -> RESPAWN.
- RESPAWN (exactly 1 clk):
  - moveResetN = 0; invuln counter loads INVULN_FRAMES.
  - Next state GROUND.
- GROUND:
  - leftCmd/rightCmd follow their keys; downCmd = 0.
  - upCmd is a jump one-shot: high for exactly one frame (from the startOfFrame where upPressed is first sampled high to the next startOfFrame). It re-arms only after upPressed is sampled low at a startOfFrame.
  - At startOfFrame:
    - onRope and (up or down) -> CLIMB.
    - else neither onLedge nor onRope -> AIR; fall counter cleared.
- AIR:
  - left/right pass through; up/down forced 0.
  - At startOfFrame:
    - onRope -> CLIMB (priority over ledge).
    - else onLedge -> GROUND.
    - else fall counter +1; reaching MAX_FALL_FRAMES -> HIT.
- CLIMB:
  - All four keys pass through as levels.
  - At startOfFrame:
    - not onRope and onLedge -> GROUND.
    - not onRope and not onLedge -> AIR.
- Hit detection:
  - In GROUND, AIR or CLIMB, objectHit with invincible = 0 -> HIT on the next clk, in any cycle.
  - Hit has priority over every frame transition in the same cycle.
- HIT:
  - All Cmd outputs 0; counts HIT_FRAMES startOfFrame pulses.
  - On expiry: if livesLeft = 1 -> livesLeft = 0, GAMEOVER; else livesLeft - 1, RESPAWN.
- GAMEOVER:
  - gameOver = 1; all Cmd outputs 0.
  - gameStart -> livesLeft = INIT_LIVES, RESPAWN.
- Invulnerability counter: decrements at each startOfFrame while nonzero, in every state; saturates at 0.
- Ignored inputs: gameStart outside IDLE and GAMEOVER; objectHit in HIT, RESPAWN, IDLE and GAMEOVER.
- Simultaneous startOfFrame and objectHit: the hit wins and no counter in the frame path advances.
- Reset asserted mid-operation (any state, including HIT) -> immediate return to reset values.
- Unused state codes (7) -> IDLE on the next clk.

Test Plan:
- Reset, gameStart pulse:
  - moveResetN low for exactly 1 clk, then motionState = 1, livesLeft = 3, invincible = 1.
  - invincible drops after 60 frames.
- GROUND, onLedge = 1, upPressed held for 5 frames:
  - upCmd high for exactly 1 frame.
  - Release then press again -> second 1-frame pulse.
- GROUND, onLedge and onRope drop to 0:
  - AIR at the next startOfFrame.
  - 40 frames without footing -> HIT; 45 frames later livesLeft = 2, RESPAWN pulse seen.
- CLIMB, onRope = 1, downPressed -> downCmd = 1 after 1 clk.
  - onRope = 0, onLedge = 1 at startOfFrame -> GROUND and downCmd = 0.
- objectHit during invulnerability -> no state change.
  - After expiry, objectHit on the same clk as startOfFrame with onLedge = 0 -> HIT, not AIR.
- Three successive hits:
  - livesLeft 3 -> 2 -> 1 -> 0; GAMEOVER with gameOver = 1 and all Cmd outputs 0.
  - gameStart -> livesLeft = 3, RESPAWN.
  - resetN low mid-HIT -> IDLE immediately.
